aes_key_schedule: RTL and testbench

Iterative AES-128 key-expansion stage that generates round keys 0-10 on demand, one per handshake, from a 128-bit cipher key. It uses the team's round-constant lookup (`rcon`, indexed by round 1-10) and four instances of the byte S-box for SubWord. It feeds the round-key input of the encryption datapath, which pulls keys with a ready/valid handshake.

---
 rtl/aes_key_schedule_if.sv | 36 +++
 rtl/aes_key_schedule.sv | 181 ++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_if.sv
// ----------------------------------------------------------------------------
// aes_key_schedule_if
//   Round-key handshake bundle between a requester (master) and the AES-128
//   key schedule (slave). The requester issues start/key and pulls round keys
//   with rk_ready. The schedule presents round_key/round_num under rk_valid
//   and reports busy/done.
//   Signals:
//     start      requester -> schedule  one-cycle request to expand key
//     key        requester -> schedule  [0:127] cipher key, bit 0 = MSB
//     rk_ready   requester -> schedule  consumer accepts the current key
//     round_key  schedule -> requester  [0:127] current round key
//     rk_valid   schedule -> requester  round_key/round_num valid
//     round_num  schedule -> requester  [0:3] round index 0-10
//     busy       schedule -> requester  expansion in progress
//     done       schedule -> requester  pulse after round 10 accepted
// ----------------------------------------------------------------------------
interface aes_key_schedule_if;
    logic         start;
    logic [0:127] key;
    logic         rk_ready;
    logic [0:127] round_key;
    logic         rk_valid;
    logic [0:3]   round_num;
    logic         busy;
    logic         done;

    modport master (
        output start, key, rk_ready,
        input  round_key, rk_valid, round_num, busy, done
    );

    modport slave (
        input  start, key, rk_ready,
        output round_key, rk_valid, round_num, busy, done
    );
endinterface

// File: rtl/aes_key_schedule.sv
// ----------------------------------------------------------------------------
// aes_key_schedule
//   Iterative AES-128 key expansion. On start the cipher key is loaded as
//   round key 0; each accepted round key (rk_valid & rk_ready) advances the
//   schedule by one round, up to round 10, after which done pulses for one
//   cycle and the block returns to idle.
//   Ports:
//     clk    single clock, rising edge
//     reset  synchronous, active-high
//     ks     aes_key_schedule_if.slave (start/key in, round keys out)
//   Also contains aes_sbox, the AES byte substitution used by SubWord.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// aes_sbox
//   Combinational AES S-box: multiplicative inverse in GF(2^8) (poly 0x11b)
//   followed by the affine transform.
//   Ports:
//     value   [7:0] input byte
//     result  [7:0] substituted byte
// ----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    always_comb begin
        // x^254 = x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
        // 254 = 2+4+...+128, so accumulate successive squares.
        sq  = value;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        result = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
    end
endmodule

module aes_key_schedule (
    input  logic               clk,
    input  logic               reset,
    aes_key_schedule_if.slave  ks
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t       state_reg;
    logic [0:31]  w_reg [4];
    logic [0:3]   round_reg;
    logic         valid_reg;
    logic         busy_reg;
    logic         done_reg;

    logic [0:31]  rot_word;
    logic [0:31]  sub_word;
    logic [0:31]  temp;
    logic [0:31]  w_next [4];
    logic [0:3]   rcon_index;
    logic [0:7]   rcon_byte;

    // RotWord: {b1,b2,b3,b0}
    assign rot_word = {w_reg[3][8:31], w_reg[3][0:7]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .value  (rot_word[gi*8 +: 8]),
                .result (sub_word[gi*8 +: 8])
            );
        end
    endgenerate

    // The key being computed is for round_num+1.
    assign rcon_index = round_reg + 4'd1;

    always_comb begin
        rcon_byte = 8'h00;
        case (rcon_index)
            4'd1:    rcon_byte = 8'h01;
            4'd2:    rcon_byte = 8'h02;
            4'd3:    rcon_byte = 8'h04;
            4'd4:    rcon_byte = 8'h08;
            4'd5:    rcon_byte = 8'h10;
            4'd6:    rcon_byte = 8'h20;
            4'd7:    rcon_byte = 8'h40;
            4'd8:    rcon_byte = 8'h80;
            4'd9:    rcon_byte = 8'h1b;
            4'd10:   rcon_byte = 8'h36;
            default: rcon_byte = 8'h00;
        endcase
    end

    assign temp = sub_word ^ {rcon_byte, 24'h000000};

    // Each new word chains off the previous new word, so keep the chain in
    // one block to avoid a false combinational loop on the array.
    always_comb begin
        w_next[0] = w_reg[0] ^ temp;
        w_next[1] = w_reg[1] ^ w_next[0];
        w_next[2] = w_reg[2] ^ w_next[1];
        w_next[3] = w_reg[3] ^ w_next[2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            for (int i = 0; i < 4; i++) w_reg[i] <= '0;
            round_reg <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (ks.start) begin
                        w_reg[0]  <= ks.key[0:31];
                        w_reg[1]  <= ks.key[32:63];
                        w_reg[2]  <= ks.key[64:95];
                        w_reg[3]  <= ks.key[96:127];
                        round_reg <= '0;
                        valid_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= EXPAND;
                    end
                end
                EXPAND: begin
                    // rk_valid is always high here; without rk_ready every
                    // register holds, which keeps the outputs stable.
                    if (ks.rk_ready) begin
                        if (round_reg == 4'd10) begin
                            valid_reg <= 1'b0;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            for (int i = 0; i < 4; i++) w_reg[i] <= w_next[i];
                            round_reg <= round_reg + 4'd1;
                        end
                    end
                end
                FINISH: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ks.round_key = {w_reg[0], w_reg[1], w_reg[2], w_reg[3]};
    assign ks.round_num = round_reg;
    assign ks.rk_valid  = valid_reg;
    assign ks.busy      = busy_reg;
    assign ks.done      = done_reg;
endmodule

// File: tb/tb_aes_key_schedule.sv
// ----------------------------------------------------------------------------
// tb_aes_key_schedule
//   Scoreboard bench for aes_key_schedule. When a key is started the full
//   expected schedule (from a table-driven reference model) is queued; each
//   accepted round key is popped and compared. Covers reset state, FIPS-197
//   and all-zero keys, random back-pressure with stall stability, ignored
//   start pulses, reset mid-stall and start+reset collision.
// ----------------------------------------------------------------------------
module tb_aes_key_schedule;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes_key_schedule_if ks();

    aes_key_schedule dut (
        .clk   (clk),
        .reset (reset),
        .ks    (ks)
    );

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    localparam logic [2047:0] SBOX_BITS = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]   num;
        logic [127:0] rk;
    } sb_item_t;

    sb_item_t     sb_q[$];
    logic [127:0] got_keys [11];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [2047:0] tbl;
        tbl = SBOX_BITS;
        return tbl[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    function automatic logic [7:0] rcon_of(input int r);
        logic [7:0] c;
        c = 8'h01;
        for (int i = 1; i < r; i++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
        return c;
    endfunction

    // Queue all 11 expected round keys for a given cipher key.
    task automatic push_expected(input logic [127:0] k);
        logic [31:0] w0, w1, w2, w3, t;
        sb_item_t    e;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        e.num = 4'd0; e.rk = k;
        sb_q.push_back(e);
        for (int r = 1; r <= 10; r++) begin
            t  = sub_rot(w3) ^ {rcon_of(r), 24'h000000};
            w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
            e.num = 4'(r); e.rk = {w0, w1, w2, w3};
            sb_q.push_back(e);
        end
    endtask

    // Called at a negedge with the DUT idle; start is sampled at the next edge.
    task automatic run_key(input logic [127:0] k, input bit random_ready, input bit inject);
        int           t;
        int           accepted;
        bit           stalled;
        bit           seen_done;
        logic [127:0] held_key;
        logic [3:0]   held_num;
        sb_item_t     e;

        ks.key   = k;
        ks.start = 1'b1;
        push_expected(k);
        @(negedge clk);
        ks.start = 1'b0;
        ks.key   = ~k;
        t = 1;
        check("startup_valid", ks.rk_valid, 1);
        check("startup_busy", ks.busy, 1);
        accepted  = 0;
        stalled   = 1'b0;
        seen_done = 1'b0;
        while (t <= 300 && !seen_done) begin
            if (ks.done) begin
                seen_done = 1'b1;
                check("done_vs_valid", ks.rk_valid, 0);
                check("done_busy", ks.busy, 0);
                if (!random_ready) check("done_cycle", t, 12);
            end else begin
                if (ks.rk_valid) begin
                    check("run_busy", ks.busy, 1);
                    if (stalled) begin
                        check("stall_key", ks.round_key, held_key);
                        check("stall_num", ks.round_num, held_num);
                    end
                    ks.rk_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                    if (ks.rk_ready) begin
                        if (sb_q.size() == 0) begin
                            check("sb_underflow", 1, 0);
                        end else begin
                            e = sb_q.pop_front();
                            check("round_num", ks.round_num, e.num);
                            check("round_key", ks.round_key, e.rk);
                            got_keys[e.num] = ks.round_key;
                            $display("round %0d key %h", ks.round_num, ks.round_key);
                            accepted++;
                        end
                        stalled = 1'b0;
                    end else begin
                        stalled  = 1'b1;
                        held_key = ks.round_key;
                        held_num = ks.round_num;
                    end
                end else begin
                    check("valid_gap", ks.rk_valid, 1);
                end
                if (inject && ks.rk_valid && (ks.round_num == 4'd3 || ks.round_num == 4'd10)) begin
                    ks.start = 1'b1;
                    ks.key   = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    ks.start = 1'b0;
                end
                @(negedge clk);
                t++;
            end
        end
        if (!seen_done) check("timeout", 1, 0);
        check("keys_accepted", accepted, 11);
        check("sb_empty", sb_q.size(), 0);
        sb_q.delete();
        if (inject) begin
            ks.start = 1'b1;
            ks.key   = ~k;
        end else begin
            ks.start = 1'b0;
        end
        @(negedge clk);
        ks.start = 1'b0;
        check("done_pulse", ks.done, 0);
        check("idle_valid", ks.rk_valid, 0);
        if (inject) begin
            @(negedge clk);
            check("finish_start_ignored", ks.rk_valid, 0);
            check("finish_start_busy", ks.busy, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        ks.start    = 1'b0;
        ks.key      = '0;
        ks.rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_key", ks.round_key, 0);
        check("reset_num", ks.round_num, 0);
        check("reset_valid", ks.rk_valid, 0);
        check("reset_busy", ks.busy, 0);
        check("reset_done", ks.done, 0);

        // FIPS-197 key at full rate
        run_key(FIPS_KEY, 1'b0, 1'b0);
        check("fips_r0", got_keys[0], FIPS_KEY);
        check("fips_r1", got_keys[1], FIPS_R1);
        check("fips_r10", got_keys[10], FIPS_R10);

        // all-zero key, started in the cycle after the previous return to idle
        run_key(128'h0, 1'b0, 1'b0);
        check("zero_r1", got_keys[1], ZERO_R1);
        check("zero_r10", got_keys[10], ZERO_R10);

        // random back-pressure
        run_key(FIPS_KEY, 1'b1, 1'b0);
        check("bp_r10", got_keys[10], FIPS_R10);

        // start pulses at rounds 3, 10 and in the FINISH cycle
        run_key(FIPS_KEY, 1'b0, 1'b1);
        check("inject_r10", got_keys[10], FIPS_R10);

        // random key with back-pressure
        run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);

        // reset while stalled at round 5
        ks.key      = FIPS_KEY;
        ks.start    = 1'b1;
        ks.rk_ready = 1'b1;
        @(negedge clk);
        ks.start = 1'b0;
        for (int i = 0; i < 20 && ks.round_num != 4'd5; i++) @(negedge clk);
        check("reach_r5", ks.round_num, 5);
        ks.rk_ready = 1'b0;
        @(negedge clk);
        check("r5_stalled", ks.round_num, 5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_key", ks.round_key, 0);
        check("mid_reset_num", ks.round_num, 0);
        check("mid_reset_valid", ks.rk_valid, 0);
        check("mid_reset_busy", ks.busy, 0);
        check("mid_reset_done", ks.done, 0);
        run_key(FIPS_KEY, 1'b0, 1'b0);
        check("post_reset_r10", got_keys[10], FIPS_R10);

        // start and reset together
        ks.key   = FIPS_KEY;
        ks.start = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        ks.start = 1'b0;
        reset    = 1'b0;
        check("start_reset_valid", ks.rk_valid, 0);
        check("start_reset_busy", ks.busy, 0);
        @(negedge clk);
        check("start_reset_valid2", ks.rk_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
